burst_master_port: RTL and testbench

BURST_MASTER_PORT -- requirements
Module: burst_master_port

---
 rtl/burst_master_port.sv | 220 ++++++++++++++++++++++
 tb/tb_burst_master_port.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/burst_master_port.sv
// Serial burst master: bus request, device/memory address phases,
// MSB-first write/read beats with split hold, timeout and retry.
module burst_master_port #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 16,
  parameter int DEV_W   = 4,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 64,
  parameter int RETRIES = 3
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              mode,
  output logic              wr_bus,
  input  logic              rd_bus,
  input  logic              ack,
  output logic              master_valid,
  input  logic              slave_ready,
  output logic              master_ready,
  input  logic              slave_valid,
  output logic              breq,
  input  logic              bgrant,
  input  logic              split,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic              m_mode,
  input  logic [LEN_W-1:0]  m_len,
  input  logic              m_start,
  input  logic [DATA_W-1:0] m_wr_data,
  output logic              m_wr_req,
  output logic [DATA_W-1:0] m_rd_data,
  output logic              m_rd_valid,
  output logic              m_done,
  output logic              m_err,
  output logic              m_busy
);

  localparam int MAXW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CW   = $clog2(MAXW);
  localparam int TW   = $clog2(TIMEOUT) + 1;
  localparam int RW   = $clog2(RETRIES + 1) + 1;

  localparam logic [CW-1:0] DEV_LAST = CW'(DEV_W - 1);
  localparam logic [CW-1:0] MEM_LAST = CW'(ADDR_W - DEV_W - 1);
  localparam logic [CW-1:0] DAT_LAST = CW'(DATA_W - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RT_MAX   = RW'(RETRIES);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_FETCH, S_ADDR_DEV, S_ADDR_MEM,
    S_WR_DATA, S_RD_DATA, S_SPLIT, S_TOUT, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [TW-1:0]     tout_q, tout_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic              mode_q, mode_d;
  logic              err_q, err_d;
  logic              rvld_q, rvld_d;
  logic              snd, rcv, wr_load;

  assign master_valid = (state_q == S_ADDR_DEV) |
                        (state_q == S_ADDR_MEM) |
                        (state_q == S_WR_DATA);
  assign master_ready = (state_q == S_RD_DATA);
  assign breq = !((state_q == S_IDLE) |
                  (state_q == S_TOUT) |
                  (state_q == S_DONE));
  assign wr_bus = (state_q == S_WR_DATA) ? data_q[DATA_W-1]
                                         : addr_q[ADDR_W-1];
  assign snd        = master_valid & slave_ready;
  assign rcv        = master_ready & slave_valid;
  assign mode       = mode_q;
  assign m_wr_req   = wr_load;
  assign m_rd_data  = rdata_q;
  assign m_rd_valid = rvld_q;
  assign m_done     = (state_q == S_DONE);
  assign m_err      = err_q;
  assign m_busy     = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    tout_d  = tout_q;
    retry_d = retry_q;
    mode_d  = mode_q;
    err_d   = err_q;
    rvld_d  = 1'b0;
    wr_load = 1'b0;
    unique case (state_q)
      S_IDLE: if (m_start) state_d = S_REQ;
      S_REQ: begin
        cnt_d  = '0;
        tout_d = '0;
        if (bgrant) state_d = S_FETCH;
      end
      S_FETCH: begin
        addr_d  = m_addr;
        mode_d  = m_mode;
        beat_d  = m_len;
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = S_ADDR_DEV;
      end
      S_ADDR_DEV: begin
        tout_d = tout_q + 1'b1;
        if (snd) begin
          addr_d = {addr_q[ADDR_W-2:0], 1'b0};
          cnt_d  = cnt_q + 1'b1;
        end
        if (snd && cnt_q == DEV_LAST) begin
          cnt_d = '0;
          if (ack) begin
            state_d = S_ADDR_MEM;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end else if (tout_q == TO_LAST) begin
          state_d = S_TOUT;
        end
      end
      S_ADDR_MEM: if (snd) begin
        addr_d = {addr_q[ADDR_W-2:0], 1'b0};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == MEM_LAST) begin
          cnt_d = '0;
          if (mode_q) begin
            wr_load = 1'b1;
            state_d = S_WR_DATA;
          end else begin
            state_d = S_RD_DATA;
          end
        end
      end
      S_WR_DATA: if (snd) begin
        data_d = {data_q[DATA_W-2:0], 1'b0};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == DAT_LAST) begin
          cnt_d = '0;
          if (beat_q != '0) begin
            beat_d  = beat_q - 1'b1;
            wr_load = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RD_DATA: begin
        if (rcv) begin
          data_d = {data_q[DATA_W-2:0], rd_bus};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == DAT_LAST) begin
            cnt_d   = '0;
            rdata_d = {data_q[DATA_W-2:0], rd_bus};
            rvld_d  = 1'b1;
            if (beat_q != '0) beat_d = beat_q - 1'b1;
            else state_d = S_DONE;
          end
        end
        // a bit offered alongside split is still taken
        if (split && state_d == S_RD_DATA) state_d = S_SPLIT;
      end
      S_SPLIT: if (!split) state_d = S_RD_DATA;
      S_TOUT: begin
        retry_d = retry_q + 1'b1;
        if (retry_q < RT_MAX) begin
          state_d = S_REQ;
        end else begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        retry_d = '0;
        tout_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (wr_load) data_d = m_wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
      tout_q  <= '0;
      retry_q <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      tout_q  <= tout_d;
      retry_q <= retry_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      rvld_q  <= rvld_d;
    end
  end

endmodule

// File: tb/tb_burst_master_port.sv
// Bench for burst_master_port: random slave handshakes against a
// serial-stream model of address, write and read traffic.
module tb_burst_master_port;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       mode, wr_bus, rd_bus, ack;
  logic       master_valid, slave_ready, master_ready, slave_valid;
  logic       breq, bgrant, split;
  logic [15:0] m_addr;
  logic       m_mode;
  logic [3:0] m_len;
  logic       m_start;
  logic [7:0] m_wr_data;
  logic       m_wr_req;
  logic [7:0] m_rd_data;
  logic       m_rd_valid, m_done, m_err, m_busy;

  int checks = 0;
  int errors = 0;

  byte unsigned wq[$], rq[$], obs_rd[$];
  bit exp_bits[$], obs_bits[$], rbits[$];
  int nwrreq, mv_cycles, tout_cycles, mr_bad, wi, ri, rbits_in;
  bit done_seen, err_at_done, mode_at_done, aborted;

  burst_master_port dut (
    .clk(clk), .rstn(rstn), .mode(mode), .wr_bus(wr_bus),
    .rd_bus(rd_bus), .ack(ack), .master_valid(master_valid),
    .slave_ready(slave_ready), .master_ready(master_ready),
    .slave_valid(slave_valid), .breq(breq), .bgrant(bgrant),
    .split(split), .m_addr(m_addr), .m_mode(m_mode),
    .m_len(m_len), .m_start(m_start), .m_wr_data(m_wr_data),
    .m_wr_req(m_wr_req), .m_rd_data(m_rd_data),
    .m_rd_valid(m_rd_valid), .m_done(m_done), .m_err(m_err),
    .m_busy(m_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] outs();
    return {breq, master_valid, master_ready, m_wr_req, m_rd_valid,
            m_done, m_err, m_busy, wr_bus, mode, m_rd_data};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected serial stream: address MSB-first, then each write word
  task automatic build_exp(input logic [15:0] a, input bit md,
                           input bit ackv);
    int lo;
    lo = ackv ? 0 : 12;
    exp_bits.delete();
    for (int b = 15; b >= lo; b--) exp_bits.push_back(a[b]);
    if (md && ackv)
      foreach (wq[i])
        for (int b = 7; b >= 0; b--) exp_bits.push_back(wq[i][b]);
  endtask

  task automatic fill(input int len);
    wq.delete();
    rq.delete();
    for (int i = 0; i <= len; i++) begin
      wq.push_back(8'($urandom));
      rq.push_back(8'($urandom));
    end
  endtask

  task automatic xfer(input logic [15:0] a, input bit md, input int len,
                      input bit ackv, input int rdy_pct,
                      input bit do_split, input bit abort,
                      input int budget);
    int split_left, split_idx, ab_cnt;
    bit split_done;
    m_addr = a; m_mode = md; m_len = 4'(len); ack = ackv;
    obs_bits.delete(); obs_rd.delete(); rbits.delete();
    foreach (rq[i])
      for (int b = 7; b >= 0; b--) rbits.push_back(rq[i][b]);
    nwrreq = 0; mv_cycles = 0; tout_cycles = 0; mr_bad = 0;
    wi = 0; ri = 0; rbits_in = 0;
    done_seen = 0; err_at_done = 0; mode_at_done = 0; aborted = 0;
    split_left = 0; split_idx = 0; split_done = 0; ab_cnt = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      m_start     = (cyc == 0);
      bgrant      = ($urandom_range(0, 2) != 0);
      slave_ready = ($urandom_range(1, 100) <= rdy_pct);
      slave_valid = ($urandom_range(0, 3) != 0);
      split       = 1'b0;
      if (split_left > 0) begin
        split = 1'b1; slave_valid = 1'b0;
        split_left--; split_idx++;
      end
      m_wr_data = (wi < wq.size()) ? wq[wi] : 8'h00;
      rd_bus    = (ri < rbits.size()) ? rbits[ri] : 1'b0;
      #1;
      if (split && split_idx >= 2 && master_ready) mr_bad++;
      if (master_valid && slave_ready) obs_bits.push_back(wr_bus);
      if (m_wr_req) begin nwrreq++; wi++; end
      if (master_ready && slave_valid) begin ri++; rbits_in++; end
      if (master_valid) mv_cycles++;
      if (m_busy && !breq && !m_done) tout_cycles++;
      if (m_rd_valid) obs_rd.push_back(m_rd_data);
      if (do_split && !split_done && rbits_in == 3) begin
        split_left = 10; split_done = 1;
      end
      if (abort && nwrreq > 0) ab_cnt++;
      if (abort && ab_cnt == 4) begin aborted = 1; break; end
      if (m_done) begin
        done_seen = 1; err_at_done = m_err; mode_at_done = mode;
        break;
      end
    end
    m_start = 0; split = 0; slave_ready = 0; slave_valid = 0;
  endtask

  task automatic post_idle(input bit exp_err);
    @(negedge clk); #1;
    chk("done_one_cycle", m_done, 0);
    chk("idle_after_done", m_busy, 0);
    chk("err_held", m_err, exp_err);
  endtask

  task automatic check_xfer(input string tag, input logic [15:0] a,
                            input bit md, input int len, input bit ackv);
    build_exp(a, md, ackv);
    chk({tag, "_done"}, done_seen, 1);
    chk({tag, "_err"}, err_at_done, !ackv);
    chk({tag, "_mode"}, mode_at_done, md);
    chk({tag, "_nbits"}, obs_bits.size(), exp_bits.size());
    foreach (exp_bits[i])
      if (i < obs_bits.size()) chk({tag, "_bit"}, obs_bits[i], exp_bits[i]);
    chk({tag, "_wrreq"}, nwrreq, (md && ackv) ? len + 1 : 0);
    chk({tag, "_nrd"}, obs_rd.size(), (!md && ackv) ? len + 1 : 0);
    if (!md && ackv)
      foreach (rq[i])
        if (i < obs_rd.size()) chk({tag, "_rdword"}, obs_rd[i], rq[i]);
    post_idle(!ackv);
  endtask

  initial begin
    logic [15:0] a;
    logic [23:0] pk;
    bit md;
    int len;
    ack = 1; rd_bus = 0; slave_ready = 0; slave_valid = 0;
    bgrant = 0; split = 0; m_addr = 0; m_mode = 0; m_len = 0;
    m_start = 0; m_wr_data = 0;

    #3 rstn = 0;
    #1 chk("reset_outputs", outs(), 0);
    repeat (2) @(negedge clk);
    rstn = 1;
    repeat (3) @(negedge clk);
    #1 chk("idle_without_start", {m_busy, breq}, 0);

    wq = {8'h96}; rq = {8'h00};
    xfer(16'hA35C, 1, 0, 1, 100, 0, 0, 500);
    pk = '0;
    foreach (obs_bits[i]) if (i < 24) pk = {pk[22:0], obs_bits[i]};
    chk("single_write_stream", pk, 24'hA35C96);
    check_xfer("single_write", 16'hA35C, 1, 0, 1);

    wq = {8'h00, 8'h00, 8'h00}; rq = {8'h11, 8'h22, 8'h33};
    xfer(16'h5A0F, 0, 2, 1, 70, 0, 0, 1000);
    check_xfer("read_burst", 16'h5A0F, 0, 2, 1);

    for (int t = 0; t < 6; t++) begin
      a = 16'($urandom); md = 1'($urandom); len = $urandom_range(0, 3);
      fill(len);
      xfer(a, md, len, 1, $urandom_range(40, 100), 0, 0, 2000);
      check_xfer("random", a, md, len, 1);
    end

    a = 16'($urandom); fill(1);
    xfer(a, 1, 1, 0, 60, 0, 0, 1000);
    check_xfer("nack", a, 1, 1, 0);

    a = 16'($urandom); fill(0);
    xfer(a, 1, 0, 1, 80, 0, 0, 1000);
    check_xfer("after_nack", a, 1, 0, 1);

    fill(0);
    xfer(16'hC3C3, 1, 0, 1, 0, 0, 0, 2000);
    chk("tout_done", done_seen, 1);
    chk("tout_err", err_at_done, 1);
    chk("tout_addr_cycles", mv_cycles, 256);
    chk("tout_breq_drops", tout_cycles, 4);
    chk("tout_no_bits", obs_bits.size(), 0);
    post_idle(1);

    a = 16'($urandom); fill(1);
    xfer(a, 0, 1, 1, 75, 1, 0, 1000);
    chk("split_ready_low", mr_bad, 0);
    check_xfer("split_read", a, 0, 1, 1);

    a = 16'($urandom); fill(3);
    xfer(a, 1, 3, 1, 100, 0, 1, 1000);
    chk("abort_reached", aborted, 1);
    rstn = 0;
    #1 chk("midwrite_reset_outputs", outs(), 0);
    @(negedge clk);
    rstn = 1;
    repeat (4) @(negedge clk);
    #1 chk("no_restart_after_reset", {m_busy, breq}, 0);
    a = 16'($urandom); fill(2);
    xfer(a, 1, 2, 1, 90, 0, 0, 1000);
    check_xfer("after_reset", a, 1, 2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
